// File: rtl/serial_product_deserializer.sv
// rtl/serial_product_deserializer.sv - collects a serial LSB-first product into a 2N-bit word
//
// Purpose: sits behind the shift-add multiplier, aligned to the multiplier's start pulse,
// and assembles its one-bit-per-clock product stream into a parallel word. The word is
// offered to the consumer on a valid/ready handshake.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        one-cycle pulse shared with the multiplier; (re)starts a capture
//   serial_in    product bit, LSB first, sampled only while collecting
//   product      assembled 2N-bit word, stable while valid is high
//   valid        product holds a complete, unconsumed result
//   ready        consumer accepts product when valid && ready
//   busy         waiting for or collecting a stream
//   overrun      sticky: a completed result was discarded by a new start
//   clr_overrun  clears overrun (a simultaneous overrun event wins)
module serial_product_deserializer #(
  parameter int N    = 32,
  parameter int LEAD = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           serial_in,
  output logic [2*N-1:0] product,
  output logic           valid,
  input  logic           ready,
  output logic           busy,
  output logic           overrun,
  input  logic           clr_overrun
);

  localparam int CW = (2 * N > 1) ? $clog2(2 * N) : 1;
  localparam logic [CW-1:0] LAST_BIT  = CW'(2 * N - 1);
  localparam logic [3:0]    LEAD_LOAD = 4'(LEAD - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_COLLECT = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [2*N-1:0] shreg_q, shreg_d;
  logic [2*N-1:0] product_q, product_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [3:0]     lead_q, lead_d;
  logic           valid_q, valid_d;
  logic           busy_q, busy_d;
  logic           overrun_q, overrun_d;
  logic           ovr_set;

  // A new start arriving while a result is still unaccepted throws that result away.
  assign ovr_set = start && valid_q && !ready;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    product_d = product_q;
    cnt_d     = cnt_q;
    lead_d    = lead_q;
    valid_d   = valid_q;

    case (state_q)
      S_WAIT: begin
        lead_d = lead_q - 4'd1;
        // Counter reaching zero on this edge means the next edge samples bit 0.
        if (lead_q <= 4'd1) begin
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        shreg_d = {serial_in, shreg_q[2*N-1:1]};
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          product_d = shreg_d;
          valid_d   = 1'b1;
          cnt_d     = '0;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        if (valid_q && ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: ;
    endcase

    // Start overrides everything: a pending result is either handed off (ready=1) or
    // lost (ready=0), and the start cycle itself never samples serial_in.
    if (start) begin
      shreg_d   = '0;
      cnt_d     = '0;
      product_d = product_q;
      valid_d   = 1'b0;
      lead_d    = LEAD_LOAD;
      state_d   = (LEAD == 1) ? S_COLLECT : S_WAIT;
    end

    if (ovr_set) begin
      overrun_d = 1'b1;
    end else if (clr_overrun) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end

    busy_d = (state_d == S_WAIT) || (state_d == S_COLLECT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      product_q <= '0;
      cnt_q     <= '0;
      lead_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      product_q <= product_d;
      cnt_q     <= cnt_d;
      lead_q    <= lead_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign product = product_q;
  assign valid   = valid_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_serial_product_deserializer.sv
// tb/tb_serial_product_deserializer.sv - directed bench for serial_product_deserializer
module tb_serial_product_deserializer;

  logic       clk;
  logic       rst;
  logic       clr;
  logic       st_a, si_a, rd_a;
  logic [7:0] pr_a;
  logic       vl_a, bz_a, ov_a;
  logic       st_b, si_b, rd_b;
  logic [7:0] pr_b;
  logic       vl_b, bz_b, ov_b;

  int vecs = 0;
  int errs = 0;

  serial_product_deserializer #(.N(4), .LEAD(1)) dut_a (
    .clk(clk), .rst(rst), .start(st_a), .serial_in(si_a), .product(pr_a),
    .valid(vl_a), .ready(rd_a), .busy(bz_a), .overrun(ov_a), .clr_overrun(clr)
  );

  serial_product_deserializer #(.N(4), .LEAD(3)) dut_b (
    .clk(clk), .rst(rst), .start(st_b), .serial_in(si_b), .product(pr_b),
    .valid(vl_b), .ready(rd_b), .busy(bz_b), .overrun(ov_b), .clr_overrun(clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_a(input logic [7:0] w);
    for (int k = 0; k < 8; k++) begin
      si_a = w[k];
      tick();
    end
    si_a = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] w);
    for (int k = 0; k < 8; k++) begin
      si_b = w[k];
      tick();
    end
    si_b = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0;
    st_a = 1'b0; si_a = 1'b0; rd_a = 1'b0;
    st_b = 1'b0; si_b = 1'b0; rd_b = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_product", 16'(pr_a), 16'h00);
    chk("rst_valid",   16'(vl_a), 16'h0);
    chk("rst_busy",    16'(bz_a), 16'h0);
    chk("rst_overrun", 16'(ov_a), 16'h0);

    // LEAD=1: stream 0x0F on edges 1..8, ready held high
    rd_a = 1'b1;
    st_a = 1'b1;
    tick();
    st_a = 1'b0;
    begin
      logic [7:0] w;
      w = 8'h0F;
      for (int k = 0; k < 8; k++) begin
        si_a = w[k];
        chk("t1_busy_collect", 16'(bz_a), 16'h1);
        chk("t1_valid_early",  16'(vl_a), 16'h0);
        tick();
      end
      si_a = 1'b0;
    end
    chk("t1_valid",   16'(vl_a), 16'h1);
    chk("t1_product", 16'(pr_a), 16'h0F);
    chk("t1_busy_done", 16'(bz_a), 16'h0);
    tick();
    chk("t1_valid_clr",  16'(vl_a), 16'h0);
    chk("t1_product_hold", 16'(pr_a), 16'h0F);

    // LEAD=3: 0xA5 beginning at edge 3, ready low for 5 cycles
    rd_b = 1'b0;
    st_b = 1'b1;
    tick();
    st_b = 1'b0;
    chk("t2_busy_wait", 16'(bz_b), 16'h1);
    tick();
    tick();
    chk("t2_valid_wait", 16'(vl_b), 16'h0);
    send_b(8'hA5);
    chk("t2_valid",   16'(vl_b), 16'h1);
    chk("t2_product", 16'(pr_b), 16'hA5);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_valid_hold",   16'(vl_b), 16'h1);
      chk("t2_product_hold", 16'(pr_b), 16'hA5);
    end
    rd_b = 1'b1;
    tick();
    rd_b = 1'b0;
    chk("t2_valid_clr",  16'(vl_b), 16'h0);
    chk("t2_product_end", 16'(pr_b), 16'hA5);
    chk("t2_overrun",    16'(ov_b), 16'h0);

    // Overrun: 0x3C left unconsumed, then a new start and 0x81
    rd_a = 1'b0;
    st_a = 1'b1;
    tick();
    st_a = 1'b0;
    send_a(8'h3C);
    chk("t3_valid",   16'(vl_a), 16'h1);
    chk("t3_product", 16'(pr_a), 16'h3C);
    chk("t3_no_ovr",  16'(ov_a), 16'h0);
    st_a = 1'b1;
    tick();
    st_a = 1'b0;
    chk("t3_overrun",   16'(ov_a), 16'h1);
    chk("t3_valid_lost", 16'(vl_a), 16'h0);
    send_a(8'h81);
    chk("t3_valid2",   16'(vl_a), 16'h1);
    chk("t3_product2", 16'(pr_a), 16'h81);
    chk("t3_ovr_sticky", 16'(ov_a), 16'h1);
    rd_a = 1'b1;
    tick();
    rd_a = 1'b0;
    chk("t3_valid_clr", 16'(vl_a), 16'h0);
    chk("t3_ovr_still", 16'(ov_a), 16'h1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t3_ovr_cleared", 16'(ov_a), 16'h0);

    // Restart mid-capture: three 1s, then restart and 0x12
    rd_a = 1'b1;
    st_a = 1'b1;
    tick();
    st_a = 1'b0;
    si_a = 1'b1;
    tick();
    tick();
    tick();
    si_a = 1'b1;
    st_a = 1'b1;
    tick();
    st_a = 1'b0;
    chk("t4_busy_restart", 16'(bz_a), 16'h1);
    send_a(8'h12);
    chk("t4_valid",   16'(vl_a), 16'h1);
    chk("t4_product", 16'(pr_a), 16'h12);
    chk("t4_no_ovr",  16'(ov_a), 16'h0);
    tick();
    chk("t4_valid_clr", 16'(vl_a), 16'h0);

    // Handshake and start in the same cycle
    rd_a = 1'b0;
    st_a = 1'b1;
    tick();
    st_a = 1'b0;
    send_a(8'h5A);
    chk("t6_valid",   16'(vl_a), 16'h1);
    chk("t6_product", 16'(pr_a), 16'h5A);
    st_a = 1'b1;
    rd_a = 1'b1;
    tick();
    st_a = 1'b0;
    rd_a = 1'b0;
    chk("t6_no_ovr",    16'(ov_a), 16'h0);
    chk("t6_valid_clr", 16'(vl_a), 16'h0);
    chk("t6_busy",      16'(bz_a), 16'h1);
    send_a(8'hC3);
    chk("t6_valid2",   16'(vl_a), 16'h1);
    chk("t6_product2", 16'(pr_a), 16'hC3);
    chk("t6_no_ovr2",  16'(ov_a), 16'h0);

    // Overrun set wins over a simultaneous clear
    st_a = 1'b1;
    clr = 1'b1;
    tick();
    st_a = 1'b0;
    clr = 1'b0;
    chk("t7_set_wins", 16'(ov_a), 16'h1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t7_cleared", 16'(ov_a), 16'h0);

    // Reset while sampling bit 5, then 20 idle clocks
    st_a = 1'b1;
    tick();
    st_a = 1'b0;
    si_a = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      si_a = 1'($urandom_range(0, 1));
      chk("t5_valid",   16'(vl_a), 16'h0);
      chk("t5_busy",    16'(bz_a), 16'h0);
      chk("t5_product", 16'(pr_a), 16'h00);
      tick();
    end
    chk("t5_overrun", 16'(ov_a), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
